hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Sits beside the ID stage and drives the stall/flush inputs of the PC register, IF_ID, and the ID_EX bubble.
- Detects load-use and branch-operand hazards and runs a small FSM that holds the front end for a fixed number of cycles.
- Issues IF_ID flushes for taken branches and jumps (j, jal, jr), and selects MEM-to-ID forwarding for branch compares.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the optional performance counters.

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- Rs_D  in  REG_AW  rs field of the instruction in ID
- Rt_D  in  REG_AW  rt field of the instruction in ID
- UsesRt_D  in  1  ID instruction reads rt (R-type, beq/bne, sw)
- Branch_D  in  1  beq/bne in ID
- Jump_D  in  1  j/jal/jr in ID
- Jr_D  in  1  jr in ID (reads rs)
- BranchTaken_D  in  1  ID comparator result, valid when Branch_D
- RegWrite_E  in  1  EX-stage instruction writes a register
- MemtoReg_E  in  1  EX-stage instruction is lw
- WriteReg_E  in  REG_AW  EX destination register
- RegWrite_M  in  1  MEM-stage instruction writes a register
- MemtoReg_M  in  1  MEM-stage instruction is lw
- WriteReg_M  in  REG_AW  MEM destination register
- Stall_F  out  1  hold PC
- Stall_D  out  1  hold IF_ID (maps to IF_ID Stall)
- Flush_D  out  1  zero IF_ID (maps to IF_ID Flush)
- Flush_E  out  1  insert bubble into ID_EX
- FwdA_D  out  1  select MEM ALU result for rs compare in ID
- FwdB_D  out  1  select MEM ALU result for rt compare in ID
- StallCycles  out  CNT_W  stall cycle count (optional feature)
- FlushCount  out  CNT_W  flush count (optional feature)

Behaviour:
- Match(r, w): r == w and r != 0. Register $0 never causes a hazard.
- Reads of the ID instruction:
  - rs is read when R-type, I-type, branch or Jr_D.
  - rt is read when UsesRt_D.
- Required stall count N, evaluated in RUN only:
  - N = 2: Branch_D/Jr_D, and a read matches WriteReg_E with MemtoReg_E.
  - N = 1: any of the following.
    - Load-use: a read matches WriteReg_E with MemtoReg_E, and not branch/jr.
    - Branch/jr with a read matching WriteReg_E with RegWrite_E and not MemtoReg_E.
    - Branch/jr with a read matching WriteReg_M with MemtoReg_M.
  - N = 0: otherwise.
- FSM states: RUN, STALL1, STALL2.
  - RUN, N=0: no stall.
  - RUN, N=1: stall this cycle, then return to RUN.
  - RUN, N=2: stall this cycle, go to STALL1, then RUN.
  - STALL1 unconditionally stalls for 1 cycle, then returns to RUN. No re-detection inside STALL1.
  - STALL2 is reserved for a 3-cycle sequence and is unreachable with the current rules. It decodes as STALL1 and is a safe default.
- Stall cycle outputs: Stall_F = Stall_D = Flush_E = 1, Flush_D = 0. Stall detection is combinational in RUN, so the first stall cycle has zero latency.
- Flush, in a non-stall RUN cycle: Flush_D = 1 when (Branch_D & BranchTaken_D) | Jump_D.
  - One cycle only.
  - Stall always takes priority over flush; the branch resolves after the stall.
- FwdA_D = RegWrite_M & !MemtoReg_M & Match(Rs_D, WriteReg_M). FwdB_D is the same with Rt_D.
  - Both are combinational and active in every state.
- Reset (synchronous):
  - State goes to RUN and counters clear.
  - During the RESET cycle all stall/flush outputs are 0, including a reset asserted mid-stall.
  - The first cycle after reset behaves as RUN.

Optional Feature:
- HAZARD_PERF_EN defined:
  - StallCycles increments on every cycle with Stall_D = 1.
  - FlushCount increments on every cycle with Flush_D = 1.
  - Both wrap at 2^CNT_W, clear on RESET, and are registered (visible the next cycle).
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg holds:
  - state enum (RUN=2'd0, STALL1=2'd1, STALL2=2'd2);
  - REG_ZERO = 5'd0;
  - opcode/funct constants for beq, bne, j, jal, jr, lw, sw.
- One sub-module, hazard_detect: purely combinational; produces N and the forward selects. The top level holds the FSM and counters.

Test Plan:
- lw $t0 in EX (WriteReg_E=8, MemtoReg_E=1); add reading rs=8 in ID → one cycle with Stall_F=Stall_D=Flush_E=1, then RUN.
- beq rs=8 in ID; lw with WriteReg_E=8 in EX → 2 consecutive stall cycles, then with BranchTaken_D=1 Flush_D=1 for exactly one cycle. StallCycles=2, FlushCount=1 (with HAZARD_PERF_EN).
- bne rt=9; ALU op with WriteReg_M=9, RegWrite_M=1, MemtoReg_M=0 → no stall, FwdB_D=1. With WriteReg_M=0 instead → FwdB_D=0.
- Jump_D=1 while a load-use match is present → the stall cycle comes first with Flush_D=0. In the next cycle (no match) Flush_D=1.
- RESET asserted in STALL1 → in the RESET cycle all outputs are 0. The next cycle is RUN and counters read 0.
- lw with WriteReg_E=0; ID reads rs=0 → no stall and no forward.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL1 = 2'd1,
    STALL2 = 2'd2
  } state_t;

  // Number of front-end hold cycles a hazard needs, evaluated in RUN.
  typedef enum logic [1:0] {
    N_NONE = 2'd0,
    N_ONE  = 2'd1,
    N_TWO  = 2'd2
  } stall_n_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FUNCT_JR = 6'h08;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX/MEM hazard inputs and stall/flush/forward outputs of hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] Rs_D;
  logic [REG_AW-1:0] Rt_D;
  logic              UsesRt_D;
  logic              Branch_D;
  logic              Jump_D;
  logic              Jr_D;
  logic              BranchTaken_D;
  logic              RegWrite_E;
  logic              MemtoReg_E;
  logic [REG_AW-1:0] WriteReg_E;
  logic              RegWrite_M;
  logic              MemtoReg_M;
  logic [REG_AW-1:0] WriteReg_M;
  logic              Stall_F;
  logic              Stall_D;
  logic              Flush_D;
  logic              Flush_E;
  logic              FwdA_D;
  logic              FwdB_D;
  logic [CNT_W-1:0]  StallCycles;
  logic [CNT_W-1:0]  FlushCount;

  modport master (
    output Rs_D, Rt_D, UsesRt_D, Branch_D, Jump_D, Jr_D, BranchTaken_D,
           RegWrite_E, MemtoReg_E, WriteReg_E, RegWrite_M, MemtoReg_M, WriteReg_M,
    input  Stall_F, Stall_D, Flush_D, Flush_E, FwdA_D, FwdB_D, StallCycles, FlushCount
  );

  modport slave (
    input  Rs_D, Rt_D, UsesRt_D, Branch_D, Jump_D, Jr_D, BranchTaken_D,
           RegWrite_E, MemtoReg_E, WriteReg_E, RegWrite_M, MemtoReg_M, WriteReg_M,
    output Stall_F, Stall_D, Flush_D, Flush_E, FwdA_D, FwdB_D, StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// Combinational hazard detection: required stall count and MEM-to-ID forward selects.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              uses_rt,
  input  logic              branch,
  input  logic              jump,
  input  logic              jr,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic [REG_AW-1:0] writereg_e,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic [REG_AW-1:0] writereg_m,
  output stall_n_t          need,
  output logic              fwd_a,
  output logic              fwd_b
);

  function automatic logic reg_match(input logic [REG_AW-1:0] r, input logic [REG_AW-1:0] w);
    return (r == w) && (r != REG_AW'(REG_ZERO));
  endfunction

  logic bj;
  logic rs_read;
  logic hit_e;
  logic hit_m;

  // Only j/jal leave rs unread; every other ID instruction reads it.
  assign bj      = branch | jr;
  assign rs_read = ~(jump & ~jr);
  assign hit_e   = (rs_read & reg_match(rs, writereg_e)) | (uses_rt & reg_match(rt, writereg_e));
  assign hit_m   = (rs_read & reg_match(rs, writereg_m)) | (uses_rt & reg_match(rt, writereg_m));

  always_comb begin
    need = N_NONE;
    if (bj & memtoreg_e & hit_e)
      need = N_TWO;
    else if ((~bj & memtoreg_e & hit_e) |
             (bj & regwrite_e & ~memtoreg_e & hit_e) |
             (bj & memtoreg_m & hit_m))
      need = N_ONE;
  end

  assign fwd_a = regwrite_m & ~memtoreg_m & reg_match(rs, writereg_m);
  assign fwd_b = regwrite_m & ~memtoreg_m & reg_match(rt, writereg_m);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller top: stall FSM, flush generation and optional
// performance counters (enabled with HAZARD_PERF_EN).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic        CLOCK,
  input  logic        RESET,
  hazard_ctrl_if.slave bus
);

  stall_n_t need;
  state_t   state;
  state_t   state_nxt;
  logic     stall;
  logic     flush_d;

  hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .rs         (bus.Rs_D),
    .rt         (bus.Rt_D),
    .uses_rt    (bus.UsesRt_D),
    .branch     (bus.Branch_D),
    .jump       (bus.Jump_D),
    .jr         (bus.Jr_D),
    .regwrite_e (bus.RegWrite_E),
    .memtoreg_e (bus.MemtoReg_E),
    .writereg_e (bus.WriteReg_E),
    .regwrite_m (bus.RegWrite_M),
    .memtoreg_m (bus.MemtoReg_M),
    .writereg_m (bus.WriteReg_M),
    .need       (need),
    .fwd_a      (bus.FwdA_D),
    .fwd_b      (bus.FwdB_D)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= RUN;
    else       state <= state_nxt;
  end

  // STALL1 ignores the hazard inputs; STALL2 is never entered but decodes like STALL1.
  always_comb begin
    state_nxt = RUN;
    case (state)
      RUN:     state_nxt = (need == N_TWO) ? STALL1 : RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Stall outranks flush: a taken branch or jump flushes only once the stall is over.
  always_comb begin
    stall   = 1'b0;
    flush_d = 1'b0;
    if (!RESET) begin
      if (state != RUN || need != N_NONE)
        stall = 1'b1;
      else
        flush_d = (bus.Branch_D & bus.BranchTaken_D) | bus.Jump_D;
    end
  end

  assign bus.Stall_F = stall;
  assign bus.Stall_D = stall;
  assign bus.Flush_E = stall;
  assign bus.Flush_D = flush_d;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)   stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_d) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.StallCycles = stall_cnt;
  assign bus.FlushCount  = flush_cnt;
`else
  assign bus.StallCycles = CNT_W'(0);
  assign bus.FlushCount  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (counter checks follow HAZARD_PERF_EN).
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  localparam logic [5:0] OUT_IDLE  = 6'b000000;
  localparam logic [5:0] OUT_STALL = 6'b110100;
  localparam logic [5:0] OUT_FLUSH = 6'b001000;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz_if ();

  hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (hz_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {Stall_F, Stall_D, Flush_D, Flush_E, FwdA_D, FwdB_D}
  function automatic logic [5:0] outs();
    return {hz_if.Stall_F, hz_if.Stall_D, hz_if.Flush_D, hz_if.Flush_E, hz_if.FwdA_D, hz_if.FwdB_D};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic br, input logic taken, input logic jmp, input logic jr);
    hz_if.Rs_D = rs;  hz_if.Rt_D = rt;  hz_if.UsesRt_D = uses_rt;
    hz_if.Branch_D = br;  hz_if.BranchTaken_D = taken;
    hz_if.Jump_D = jmp;  hz_if.Jr_D = jr;
  endtask

  task automatic set_ex(input logic rw, input logic m2r, input logic [4:0] wr);
    hz_if.RegWrite_E = rw;  hz_if.MemtoReg_E = m2r;  hz_if.WriteReg_E = wr;
  endtask

  task automatic set_mem(input logic rw, input logic m2r, input logic [4:0] wr);
    hz_if.RegWrite_M = rw;  hz_if.MemtoReg_M = m2r;  hz_if.WriteReg_M = wr;
  endtask

  task automatic idle();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ex(1'b0, 1'b0, 5'd0);
    set_mem(1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #4;
    tests++;
    if (outs() !== OUT_IDLE) begin
      fails++; $display("FAIL reset_cycle: got %b want %b", outs(), OUT_IDLE);
    end
    next_cycle();
    rst = 1'b0;
    #4;
    tests++;
    if (outs() !== OUT_IDLE) begin
      fails++; $display("FAIL post_reset_run: got %b want %b", outs(), OUT_IDLE);
    end
    tests++;
    if (hz_if.StallCycles !== 32'd0 || hz_if.FlushCount !== 32'd0) begin
      fails++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hz_if.StallCycles, hz_if.FlushCount);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    set_id(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ex(1'b1, 1'b1, 5'd8);
    #4;
    tests++;
    if (outs() !== OUT_STALL) begin
      fails++; $display("FAIL load_use_stall: got %b want %b", outs(), OUT_STALL);
    end
    next_cycle();
    set_ex(1'b0, 1'b0, 5'd0);
    set_mem(1'b1, 1'b1, 5'd8);
    #4;
    tests++;
    if (outs() !== OUT_IDLE) begin
      fails++; $display("FAIL load_use_release: got %b want %b", outs(), OUT_IDLE);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_branch_load();
    logic [31:0] exp_s1, exp_s, exp_f;
`ifdef HAZARD_PERF_EN
    exp_s1 = 32'd1; exp_s = 32'd2; exp_f = 32'd1;
`else
    exp_s1 = 32'd0; exp_s = 32'd0; exp_f = 32'd0;
`endif
    rst = 1'b1; idle(); next_cycle(); rst = 1'b0;
    set_id(5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_ex(1'b1, 1'b1, 5'd8);
    #4;
    tests++;
    if (outs() !== OUT_STALL) begin
      fails++; $display("FAIL br_load_stall1: got %b want %b", outs(), OUT_STALL);
    end
    next_cycle();
    set_ex(1'b0, 1'b0, 5'd0);
    set_mem(1'b1, 1'b1, 5'd8);
    #4;
    tests++;
    if (outs() !== OUT_STALL) begin
      fails++; $display("FAIL br_load_stall2: got %b want %b", outs(), OUT_STALL);
    end
    tests++;
    if (hz_if.StallCycles !== exp_s1) begin
      fails++; $display("FAIL br_load_cnt_mid: got %0d want %0d", hz_if.StallCycles, exp_s1);
    end
    next_cycle();
    set_mem(1'b0, 1'b0, 5'd0);
    #4;
    tests++;
    if (outs() !== OUT_FLUSH) begin
      fails++; $display("FAIL br_load_flush: got %b want %b", outs(), OUT_FLUSH);
    end
    next_cycle();
    idle();
    #4;
    tests++;
    if (outs() !== OUT_IDLE) begin
      fails++; $display("FAIL br_load_flush_once: got %b want %b", outs(), OUT_IDLE);
    end
    tests++;
    if (hz_if.StallCycles !== exp_s || hz_if.FlushCount !== exp_f) begin
      fails++; $display("FAIL br_load_counters: got %0d/%0d want %0d/%0d",
                        hz_if.StallCycles, hz_if.FlushCount, exp_s, exp_f);
    end
    next_cycle();
  endtask

  task automatic test_forward();
    set_id(5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    set_mem(1'b1, 1'b0, 5'd9);
    #4;
    tests++;
    if (outs() !== 6'b000001) begin
      fails++; $display("FAIL fwd_b_alu: got %b want %b", outs(), 6'b000001);
    end
    next_cycle();
    set_mem(1'b1, 1'b0, 5'd0);
    #4;
    tests++;
    if (outs() !== OUT_IDLE) begin
      fails++; $display("FAIL fwd_b_wr0: got %b want %b", outs(), OUT_IDLE);
    end
    next_cycle();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #4;
    tests++;
    if (outs() !== OUT_IDLE) begin
      fails++; $display("FAIL fwd_reg0: got %b want %b", outs(), OUT_IDLE);
    end
    next_cycle();
    set_id(5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_mem(1'b1, 1'b0, 5'd9);
    #4;
    tests++;
    if (outs() !== 6'b001011) begin
      fails++; $display("FAIL fwd_both_taken: got %b want %b", outs(), 6'b001011);
    end
    next_cycle();
    set_id(5'd9, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    set_mem(1'b1, 1'b1, 5'd9);
    #4;
    tests++;
    if (outs() !== OUT_STALL) begin
      fails++; $display("FAIL br_mem_load_stall: got %b want %b", outs(), OUT_STALL);
    end
    next_cycle();
    idle();
    #4;
    tests++;
    if (outs() !== OUT_IDLE) begin
      fails++; $display("FAIL br_mem_load_release: got %b want %b", outs(), OUT_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_jump_priority();
    set_id(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    set_ex(1'b1, 1'b0, 5'd8);
    #4;
    tests++;
    if (outs() !== OUT_STALL) begin
      fails++; $display("FAIL jr_alu_stall: got %b want %b", outs(), OUT_STALL);
    end
    next_cycle();
    set_ex(1'b0, 1'b0, 5'd0);
    set_mem(1'b1, 1'b0, 5'd8);
    #4;
    tests++;
    if (outs() !== 6'b001010) begin
      fails++; $display("FAIL jr_flush_fwd: got %b want %b", outs(), 6'b001010);
    end
    next_cycle();
    set_id(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    set_ex(1'b1, 1'b1, 5'd8);
    set_mem(1'b0, 1'b0, 5'd0);
    #4;
    tests++;
    if (outs() !== OUT_FLUSH) begin
      fails++; $display("FAIL j_no_rs_read: got %b want %b", outs(), OUT_FLUSH);
    end
    next_cycle();
    set_id(5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #4;
    tests++;
    if (outs() !== OUT_STALL) begin
      fails++; $display("FAIL jump_load_use_stall: got %b want %b", outs(), OUT_STALL);
    end
    next_cycle();
    set_ex(1'b0, 1'b0, 5'd0);
    #4;
    tests++;
    if (outs() !== OUT_FLUSH) begin
      fails++; $display("FAIL jump_flush_after: got %b want %b", outs(), OUT_FLUSH);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_reset_mid_stall();
    set_id(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_ex(1'b1, 1'b1, 5'd8);
    #4;
    tests++;
    if (outs() !== OUT_STALL) begin
      fails++; $display("FAIL mid_stall_enter: got %b want %b", outs(), OUT_STALL);
    end
    next_cycle();
    rst = 1'b1;
    set_ex(1'b0, 1'b0, 5'd0);
    #4;
    tests++;
    if (outs() !== OUT_IDLE) begin
      fails++; $display("FAIL mid_stall_reset: got %b want %b", outs(), OUT_IDLE);
    end
    next_cycle();
    rst = 1'b0;
    idle();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #4;
    tests++;
    if (outs() !== OUT_FLUSH) begin
      fails++; $display("FAIL mid_stall_run_after: got %b want %b", outs(), OUT_FLUSH);
    end
    tests++;
    if (hz_if.StallCycles !== 32'd0 || hz_if.FlushCount !== 32'd0) begin
      fails++; $display("FAIL mid_stall_counters: got %0d/%0d want 0/0", hz_if.StallCycles, hz_if.FlushCount);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_zero_reg();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ex(1'b1, 1'b1, 5'd0);
    set_mem(1'b1, 1'b0, 5'd0);
    #4;
    tests++;
    if (outs() !== OUT_IDLE) begin
      fails++; $display("FAIL zero_reg_loaduse: got %b want %b", outs(), OUT_IDLE);
    end
    next_cycle();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #4;
    tests++;
    if (outs() !== OUT_IDLE) begin
      fails++; $display("FAIL zero_reg_branch: got %b want %b", outs(), OUT_IDLE);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_back_to_back();
    set_id(5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ex(1'b1, 1'b1, 5'd5);
    for (int i = 0; i < 2; i++) begin
      #4;
      tests++;
      if (outs() !== OUT_STALL) begin
        fails++; $display("FAIL b2b_stall%0d: got %b want %b", i, outs(), OUT_STALL);
      end
      next_cycle();
    end
    set_ex(1'b0, 1'b0, 5'd0);
    #4;
    tests++;
    if (outs() !== OUT_IDLE) begin
      fails++; $display("FAIL b2b_release: got %b want %b", outs(), OUT_IDLE);
    end
    next_cycle();
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch_load();
    test_forward();
    test_jump_priority();
    test_reset_mid_stall();
    test_zero_reg();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
